// File: rtl/riscv_defs.sv
// Shared RV32I pipeline definitions: register index width, hazard FSM
// states and the register dependency match used by hazard and forwarding logic.
package riscv_defs;

  localparam int NB_OPERAND = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hazard_state_t;

  // True when the ID instruction actually reads the register written as rd.
  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic dep(
    input logic [NB_OPERAND-1:0] rd,
    input logic [NB_OPERAND-1:0] rs1,
    input logic [NB_OPERAND-1:0] rs2,
    input logic                  use_rs1,
    input logic                  use_rs2
  );
    dep = (rd != '0) && ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned event counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int NB = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  output logic [NB-1:0] o_cnt
);

  logic [NB-1:0] cnt_q;

  // Count up on each increment request, holding once saturated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_inc && (cnt_q != {NB{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline, sitting in ID.
// Catches load-use into EX and ID-resolved branches fed by a load, drives the
// front-end enables, the ID/EX bubble and the IF/ID flush, and counts events.
// There is no valid/ready handshake here: every control output is a
// combinational decision for the current cycle, consumed by the pipeline
// registers at the next rising edge.
module hazard_detection_unit
  import riscv_defs::*;
#(
  parameter int NB_CNT = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ext_stall,
  input  logic [NB_OPERAND-1:0] i_if_id_rs1,
  input  logic [NB_OPERAND-1:0] i_if_id_rs2,
  input  logic                  i_if_id_use_rs1,
  input  logic                  i_if_id_use_rs2,
  input  logic                  i_if_id_is_branch,
  input  logic                  i_branch_taken,
  input  logic                  i_id_ex_mem_read,
  input  logic [NB_OPERAND-1:0] i_id_ex_rd,
  input  logic                  i_ex_mem_mem_read,
  input  logic [NB_OPERAND-1:0] i_ex_mem_rd,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_bubble,
  output logic                  o_if_id_flush,
  output logic [NB_CNT-1:0]     o_stall_cnt,
  output logic [NB_CNT-1:0]     o_flush_cnt,
  output hazard_state_t         o_state
);

  hazard_state_t state_q;
  hazard_state_t state_d;

  logic dep_ex;
  logic dep_mem;
  logic lu;
  logic bl1;
  logic bl2;
  logic stall;
  logic stall_inc;
  logic flush_inc;

  assign dep_ex  = dep(i_id_ex_rd, i_if_id_rs1, i_if_id_rs2, i_if_id_use_rs1, i_if_id_use_rs2);
  assign dep_mem = dep(i_ex_mem_rd, i_if_id_rs1, i_if_id_rs2, i_if_id_use_rs1, i_if_id_use_rs2);

  // A load in EX feeding ID always needs one bubble; a branch resolved in ID
  // also cannot take a forwarded load result from MEM, and a load still in EX
  // needs two bubbles before the branch can compare.
  assign lu  = i_id_ex_mem_read && dep_ex;
  assign bl1 = i_if_id_is_branch && i_ex_mem_mem_read && dep_mem;
  assign bl2 = i_if_id_is_branch && i_id_ex_mem_read && dep_ex;

  // State register; reset always returns to IDLE, even out of HOLD.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stall decision. HOLD is the second bubble of a branch
  // waiting on a load; an external stall freezes the FSM where it is.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = lu || bl1 || bl2;
        if (bl2 && !i_ext_stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (!i_ext_stall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output priority: reset, external stall, hazard stall, then normal flow
  // where a taken branch flushes IF/ID. A taken branch under a hazard stall is
  // ignored because its comparison used operands that were not ready yet.
  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (i_rst) begin
      o_pc_write    = 1'b1;
      o_if_id_write = 1'b1;
    end else if (i_ext_stall) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
    end else if (stall) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
      stall_inc      = 1'b1;
    end else if (i_branch_taken) begin
      o_if_id_flush = 1'b1;
      flush_inc     = 1'b1;
    end
  end

  sat_counter #(.NB(NB_CNT)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (stall_inc),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.NB(NB_CNT)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (flush_inc),
    .o_cnt (o_flush_cnt)
  );

  assign o_state = state_q;

endmodule
